// File: rtl/shift_right_mc_if.sv
// rtl/shift_right_mc_if.sv - start/done request bus of the multicycle right shifter
interface shift_right_mc_if;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] data_out;
    logic        done;
    logic        busy;

    modport master (
        output start, data_in, shamt, arith,
        input  data_out, done, busy
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output data_out, done, busy
    );
endinterface

// File: rtl/shift_right_mc.sv
// rtl/shift_right_mc.sv - multicycle 32-bit srl/sra, one power-of-two stage per clock; macro SHIFT_RIGHT_EARLY_EXIT_EN
module shift_right_mc (
    input  logic            clock,
    input  logic            reset,
    shift_right_mc_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_work;
    logic [31:0] r_data_out;
    logic [4:0]  r_shamt;
    logic        r_fill;
    logic [2:0]  r_k;
    logic [31:0] w_stage_out;
    logic        w_accept;
    logic        w_last_stage;

    // A request is only looked at outside SHIFT; in SHIFT the inputs are ignored entirely.
    assign w_accept = (r_state != S_SHIFT) && bus.start;

    // Apply the current power-of-two stage (2^k) to the work register if its shamt bit is set.
    always_comb begin
        w_stage_out = r_work;
        case (r_k)
            3'd4: if (r_shamt[4]) w_stage_out = {{16{r_fill}}, r_work[31:16]};
            3'd3: if (r_shamt[3]) w_stage_out = {{8{r_fill}},  r_work[31:8]};
            3'd2: if (r_shamt[2]) w_stage_out = {{4{r_fill}},  r_work[31:4]};
            3'd1: if (r_shamt[1]) w_stage_out = {{2{r_fill}},  r_work[31:2]};
            3'd0: if (r_shamt[0]) w_stage_out = {r_fill,       r_work[31:1]};
            default: w_stage_out = r_work;
        endcase
    end

`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
    logic [4:0] w_lower_mask;

    // Finish as soon as no lower stage would change the value.
    always_comb begin
        w_lower_mask = (5'd1 << r_k) - 5'd1;
        w_last_stage = (r_k == 3'd0) || ((r_shamt & w_lower_mask) == 5'd0);
    end
`else
    // Every stage runs, so the operation always ends after stage 0.
    always_comb begin
        w_last_stage = (r_k == 3'd0);
    end
`endif

    // State register; asynchronous reset discards any in-flight operation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic for IDLE -> SHIFT -> DONE with back-to-back restart from DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last_stage) w_next_state = S_DONE;
            S_DONE:  w_next_state = bus.start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, step one stage per SHIFT cycle, publish only the final value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_work     <= 32'd0;
            r_data_out <= 32'd0;
            r_shamt    <= 5'd0;
            r_fill     <= 1'b0;
            r_k        <= 3'd0;
        end else if (w_accept) begin
            r_work  <= bus.data_in;
            r_shamt <= bus.shamt;
            r_fill  <= bus.arith & bus.data_in[31];
            r_k     <= 3'd4;
        end else if (r_state == S_SHIFT) begin
            r_work <= w_stage_out;
            r_k    <= r_k - 3'd1;
            if (w_last_stage) begin
                r_data_out <= w_stage_out;
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.done     = (r_state == S_DONE);
    assign bus.busy     = (r_state == S_SHIFT);
endmodule

// File: tb/tb_shift_right_mc.sv
// tb/tb_shift_right_mc.sv - self-checking bench for shift_right_mc
module tb_shift_right_mc;
`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    shift_right_mc_if bus ();

    shift_right_mc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int overlap  = 0;
    int exp_done = 0;

    always @(negedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.done === 1'b1 && bus.busy === 1'b1) overlap++;
    end

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;
        int          lat_n;
        int          lat_e;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        logic signed [31:0] sd;
        sd = $signed(d);
        if (a) return $unsigned(sd >>> s);
        return d >> s;
    endfunction

    function automatic int ref_latency(input logic [4:0] s);
        int lo;
        lo = 5;
        for (int i = 4; i >= 0; i--) if (s[i]) lo = i;
        if (!EARLY) return 5;
        if (s == 5'd0) return 1;
        return 5 - lo;
    endfunction

    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          output logic [31:0] res, output int lat);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.shamt   = s;
        bus.arith   = a;
        @(posedge clock);
        @(negedge clock);
        bus.start   = 1'b0;
        bus.data_in = 32'($urandom);
        bus.shamt   = 5'($urandom);
        bus.arith   = 1'($urandom);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        res = bus.data_out;
        exp_done++;
        @(negedge clock);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          g;
        int          d0;
        logic [31:0] rd;

        vecs[0] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001, 5, 5};
        vecs[1] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 5, 5};
        vecs[2] = '{32'h7FFFFFF0, 5'd4,  1'b1, 32'h07FFFFFF, 5, 3};
        vecs[3] = '{32'h12345678, 5'd0,  1'b0, 32'h12345678, 5, 1};
        vecs[4] = '{32'hF0000000, 5'd4,  1'b0, 32'h0F000000, 5, 3};
        vecs[5] = '{32'hFFFFFFFF, 5'd8,  1'b0, 32'h00FFFFFF, 5, 2};
        vecs[6] = '{32'h80000001, 5'd16, 1'b1, 32'hFFFF8000, 5, 1};
        vecs[7] = '{32'h0000FFFF, 5'd1,  1'b1, 32'h00007FFF, 5, 5};

        bus.start   = 1'b0;
        bus.data_in = 32'd0;
        bus.shamt   = 5'd0;
        bus.arith   = 1'b0;

        #12;
        check("reset_data_out", bus.data_out, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].d, vecs[i].s, vecs[i].a, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(EARLY ? vecs[i].lat_e : vecs[i].lat_n));
        end

        // Asynchronous reset in the middle of a shift.
        @(negedge clock);
        bus.start   = 1'b1;
        bus.data_in = 32'hDEADBEEF;
        bus.shamt   = 5'd12;
        bus.arith   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);
        #2;
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check("async_rst_data_out", bus.data_out, 32'd0);
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        check("no_done_after_reset", 32'(done_cnt), 32'(d0));
        run_op(32'hDEADBEEF, 5'd12, 1'b1, res, lat);
        check("post_reset_result", res, 32'hFFFDEADB);
        check("post_reset_latency", 32'(lat), 32'(ref_latency(5'd12)));

        // start held through SHIFT with new operands: ignored until DONE.
        @(negedge clock);
        bus.start   = 1'b1;
        bus.data_in = 32'hF0000000;
        bus.shamt   = 5'd4;
        bus.arith   = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.data_in = 32'hFFFFFFFF;
        bus.shamt   = 5'd8;
        check("hold_busy", {31'd0, bus.busy}, 32'd1);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("hold_first_latency", 32'(lat), 32'(ref_latency(5'd4)));
        check("hold_first_result", bus.data_out, 32'h0F000000);
        @(posedge clock);
        @(negedge clock);
        g = 1;
        bus.start = 1'b0;
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            @(negedge clock);
            g++;
            if (bus.done === 1'b1) break;
        end
        check("b2b_gap", 32'(g), 32'(1 + ref_latency(5'd8)));
        check("b2b_second_result", bus.data_out, 32'h00FFFFFF);
        exp_done += 2;

        // Random operand, every shift amount, both modes.
        for (int s = 0; s < 32; s++) begin
            for (int a = 0; a < 2; a++) begin
                rd = $urandom;
                if (s[0]) rd[31] = 1'b1;
                run_op(rd, 5'(s), 1'(a), res, lat);
                check($sformatf("sweep_s%0d_a%0d_result", s, a), res, ref_shift(rd, 5'(s), 1'(a)));
                check($sformatf("sweep_s%0d_a%0d_latency", s, a), 32'(lat), 32'(ref_latency(5'(s))));
            end
        end

        repeat (3) @(posedge clock);
        check("done_pulse_count", 32'(done_cnt), 32'(exp_done));
        check("done_busy_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
